// File: rtl/usb_rx.sv
// usb_rx: USB 1.1 full-speed device receiver.
// Recovers bit timing from D+/D-, NRZI-decodes, destuffs, frames SYNC/PID/EOP,
// classifies host packets and streams DATA payload bytes into the endpoint FIFO.
// Optional feature macro: USB_RX_CRC16_EN (bit-serial CRC16 check on DATA packets).
module usb_rx #(
   parameter int         CLKS_PER_BIT = 8,
   parameter logic [6:0] DEV_ADDR     = 7'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dplus_in,
   input  logic       dminus_in,
   input  logic [6:0] buffer_occupancy,
   output logic [2:0] rx_packet,
   output logic       rx_transfer_active,
   output logic       rx_error,
   output logic       rx_data_ready,
   output logic       flush,
   output logic       store_rx_packet_data,
   output logic [7:0] rx_packet_data
);

   localparam int TW = $clog2(CLKS_PER_BIT);

   localparam logic [2:0] P_NONE  = 3'd0;
   localparam logic [2:0] P_OUT   = 3'd1;
   localparam logic [2:0] P_IN    = 3'd2;
   localparam logic [2:0] P_DATA0 = 3'd3;
   localparam logic [2:0] P_DATA1 = 3'd4;
   localparam logic [2:0] P_ACK   = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_PID, S_TOKEN, S_DATA, S_EOPW, S_EOPJ, S_ERR
   } state_t;

   state_t state, state_nxt;

   logic          dp_s1, dp_s2, dp_r, dm_s1, dm_s2, dm_r;
   logic [TW-1:0] timer;
   logic          strobe, se0, line_j, nrzi, last_dp, se0_prev;
   logic          sync_start, destuff_on, stuff_slot, data_bit, stuff_err, byte_done;
   logic [6:0]    shreg;
   logic [7:0]    new_byte;
   logic [3:0]    bitcnt;
   logic [2:0]    ones;
   logic [6:0]    addr;
   logic [2:0]    pend, pid_code;
   logic [7:0]    hold0, hold1;
   logic [1:0]    nheld;
   logic          do_store, do_flush, pkt_end, crc_bad;

   // Line observed one register after the synchronizers; edges on D+ realign the bit timer.
   assign se0        = !dp_r && !dm_r;
   assign line_j     = dp_r && !dm_r;
   assign nrzi       = (dp_r == last_dp);
   assign strobe     = !rst && (timer == TW'(CLKS_PER_BIT / 2));
   assign sync_start = (state == S_IDLE) && !dp_s2 && dm_s2 && dp_r;
   assign destuff_on = (state == S_PID) || (state == S_TOKEN) ||
                       (state == S_DATA) || (state == S_EOPW);
   assign stuff_slot = destuff_on && (ones == 3'd6);
   assign data_bit   = strobe && !se0 && !stuff_slot;
   assign stuff_err  = strobe && !se0 && stuff_slot && nrzi;
   assign new_byte   = {nrzi, shreg};
   assign byte_done  = data_bit && (bitcnt[2:0] == 3'd7);
   assign rx_transfer_active = (state != S_IDLE);

   // Synchronize both pins, keep one edge-detect stage, and run the bit timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         dp_s1 <= 1'b1; dp_s2 <= 1'b1; dp_r <= 1'b1;
         dm_s1 <= 1'b0; dm_s2 <= 1'b0; dm_r <= 1'b0;
         timer <= '0;
      end else begin
         dp_s1 <= dplus_in;  dp_s2 <= dp_s1; dp_r <= dp_s2;
         dm_s1 <= dminus_in; dm_s2 <= dm_s1; dm_r <= dm_s2;
         if (dp_s2 != dp_r)
            timer <= '0;
         else if (timer == TW'(CLKS_PER_BIT - 1))
            timer <= '0;
         else
            timer <= timer + 1'b1;
      end
   end

   // Map the assembled byte onto a packet code; anything unlisted is invalid.
   always_comb begin
      pid_code = P_NONE;
      case (new_byte)
         8'hE1:   pid_code = P_OUT;
         8'h69:   pid_code = P_IN;
         8'hC3:   pid_code = P_DATA0;
         8'h4B:   pid_code = P_DATA1;
         8'hD2:   pid_code = P_ACK;
         default: pid_code = P_NONE;
      endcase
   end

   // Packet framing state register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic plus the single-cycle store/flush/end requests.
   always_comb begin
      state_nxt = state;
      do_store  = 1'b0;
      do_flush  = 1'b0;
      pkt_end   = 1'b0;
      case (state)
         S_IDLE:  if (sync_start) state_nxt = S_SYNC;
         S_SYNC: begin
            if (strobe && se0)  state_nxt = S_ERR;
            else if (byte_done) state_nxt = (new_byte == 8'h80) ? S_PID : S_ERR;
         end
         S_PID: begin
            if (stuff_err || (strobe && se0)) state_nxt = S_ERR;
            else if (byte_done) begin
               case (pid_code)
                  P_OUT, P_IN:     state_nxt = S_TOKEN;
                  P_DATA0, P_DATA1: begin
                     state_nxt = S_DATA;
                     do_flush  = 1'b1;
                  end
                  P_ACK:           state_nxt = S_EOPW;
                  default:         state_nxt = S_ERR;
               endcase
            end
         end
         S_TOKEN: begin
            if (stuff_err || (strobe && se0))       state_nxt = S_ERR;
            else if (data_bit && bitcnt == 4'd15)   state_nxt = S_EOPW;
         end
         S_DATA: begin
            if (stuff_err) state_nxt = S_ERR;
            else if (strobe && se0)
               // The two held bytes are the CRC; a short or ragged payload is an error.
               state_nxt = (bitcnt != 4'd0 || nheld != 2'd2 || crc_bad) ? S_ERR : S_EOPJ;
            else if (byte_done && nheld == 2'd2) begin
               if (buffer_occupancy >= 7'd64) state_nxt = S_ERR;
               else                           do_store  = 1'b1;
            end
         end
         S_EOPW: begin
            if (stuff_err || data_bit) state_nxt = S_ERR;
            else if (strobe && se0)    state_nxt = S_EOPJ;
         end
         S_EOPJ: begin
            if (strobe) begin
               if (line_j) begin
                  state_nxt = S_IDLE;
                  pkt_end   = 1'b1;
               end else begin
                  state_nxt = S_ERR;
               end
            end
         end
         S_ERR:   if (strobe && line_j && se0_prev) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bit/byte assembly, destuff counter, DATA holding pipeline and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_dp <= 1'b1; se0_prev <= 1'b0;
         shreg <= '0; bitcnt <= '0; ones <= '0;
         addr <= '0; pend <= P_NONE;
         hold0 <= '0; hold1 <= '0; nheld <= '0;
         rx_packet <= P_NONE; rx_error <= 1'b0; rx_data_ready <= 1'b0;
         flush <= 1'b0; store_rx_packet_data <= 1'b0; rx_packet_data <= 8'h00;
      end else begin
         flush                <= do_flush;
         store_rx_packet_data <= do_store;
         rx_data_ready        <= pkt_end && (pend == P_DATA0 || pend == P_DATA1);
         if (strobe) begin
            last_dp  <= dp_r;
            se0_prev <= se0;
         end
         if (state == S_IDLE) begin
            bitcnt <= '0;
            ones   <= '0;
            nheld  <= '0;
         end else begin
            if (data_bit) begin
               shreg  <= new_byte[7:1];
               // Tokens count all 16 bits; every other state restarts per byte.
               bitcnt <= (byte_done && state != S_TOKEN) ? 4'd0 : bitcnt + 4'd1;
            end
            if (destuff_on && strobe && !se0)
               ones <= stuff_slot ? 3'd0 : (nrzi ? ones + 3'd1 : 3'd0);
         end
         if (state == S_PID && byte_done)
            pend <= pid_code;
         if (state == S_TOKEN && byte_done && bitcnt == 4'd7)
            addr <= new_byte[6:0];
         if (state == S_DATA && byte_done) begin
            case (nheld)
               2'd0: begin hold0 <= new_byte; nheld <= 2'd1; end
               2'd1: begin hold1 <= new_byte; nheld <= 2'd2; end
               default: begin hold0 <= hold1; hold1 <= new_byte; end
            endcase
         end
         if (do_store)
            rx_packet_data <= hold0;
         if (pkt_end && (!(pend == P_OUT || pend == P_IN) || addr == DEV_ADDR))
            rx_packet <= pend;
         if (state_nxt == S_ERR)
            rx_error <= 1'b1;
         else if (sync_start)
            rx_error <= 1'b0;
      end
   end

`ifdef USB_RX_CRC16_EN
   logic [15:0] crc;

   // Bit-serial CRC16 over payload and CRC field; a clean packet leaves the fixed residual.
   always_ff @(posedge clk) begin
      if (rst)
         crc <= 16'hFFFF;
      else if (state == S_PID && byte_done)
         crc <= 16'hFFFF;
      else if (state == S_DATA && data_bit)
         crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ nrzi) ? 16'h8005 : 16'h0000);
   end

   assign crc_bad = (crc != 16'h800D);
`else
   assign crc_bad = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx.sv
// tb_usb_rx: directed bench for usb_rx; drives NRZI/bit-stuffed line traffic
// and checks decoded packets, FIFO strobes and error handling.
module tb_usb_rx;
   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dp  = 1'b1;
   logic       dm  = 1'b0;
   logic [6:0] occ = 7'd0;
   logic [2:0] rx_packet;
   logic       rx_transfer_active, rx_error, rx_data_ready, flush, store_rx_packet_data;
   logic [7:0] rx_packet_data;

   usb_rx #(.CLKS_PER_BIT(CPB), .DEV_ADDR(7'd0)) dut (
      .clk(clk), .rst(rst), .dplus_in(dp), .dminus_in(dm), .buffer_occupancy(occ),
      .rx_packet(rx_packet), .rx_transfer_active(rx_transfer_active), .rx_error(rx_error),
      .rx_data_ready(rx_data_ready), .flush(flush),
      .store_rx_packet_data(store_rx_packet_data), .rx_packet_data(rx_packet_data)
   );

   always #5 clk = ~clk;

   int errs = 0, checks = 0;
   int n_store = 0, n_flush = 0, n_rdy = 0;
   int s0, f0, r0;
   logic [7:0] stored [0:255];
   logic [7:0] pl [0:7];
   logic cur = 1'b1;
   int ones = 0;

   // Event monitor for the single-cycle strobes.
   always @(negedge clk) begin
      if (store_rx_packet_data) begin
         stored[n_store[7:0]] = rx_packet_data;
         n_store++;
      end
      if (flush) n_flush++;
      if (rx_data_ready) n_rdy++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic j);
      dp = j; dm = ~j;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input logic stuff);
      if (!b) cur = ~cur;
      drive(cur);
      if (stuff) begin
         if (b) ones++; else ones = 0;
         if (ones == 6) begin
            cur = ~cur;
            drive(cur);
            ones = 0;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) send_bit(b[i], 1'b1);
   endtask

   task automatic send_sync();
      cur = 1'b1; ones = 0;
      for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      ones = 0;
   endtask

   // One SE0 bit, the EOP J bit, then idle J.
   task automatic send_eop();
      dp = 1'b0; dm = 1'b0;
      repeat (CPB) @(negedge clk);
      cur = 1'b1;
      for (int i = 0; i < 4; i++) drive(1'b1);
   endtask

   task automatic send_ack();
      send_sync(); send_byte(8'hD2); send_eop();
   endtask

   task automatic send_token(input logic [7:0] pid, input logic [6:0] a, input logic [3:0] ep);
      send_sync(); send_byte(pid);
      send_byte({ep[0], a});
      send_byte({5'b10101, ep[3:1]});
      send_eop();
   endtask

   // DATA packet from pl[0..n-1] plus the inverted CRC16, MSB of the register first.
   task automatic send_data(input logic [7:0] pid, input int n, input logic corrupt);
      logic [15:0] c;
      logic [7:0]  c0, c1;
      logic        fb;
      c = 16'hFFFF;
      for (int k = 0; k < n; k++)
         for (int i = 0; i < 8; i++) begin
            fb = c[15] ^ pl[k][i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
         end
      for (int i = 0; i < 8; i++) begin
         c0[i] = ~c[15-i];
         c1[i] = ~c[7-i];
      end
      if (corrupt) c1[0] = ~c1[0];
      send_sync(); send_byte(pid);
      for (int k = 0; k < n; k++) send_byte(pl[k]);
      send_byte(c0); send_byte(c1);
      send_eop();
   endtask

   task automatic snap();
      s0 = n_store; f0 = n_flush; r0 = n_rdy;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_packet", rx_packet, 3'd0);
      chk("rst_active", rx_transfer_active, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) drive(1'b1);
      chk("idle_error", rx_error, 1'b0);
      chk("idle_outs", {rx_data_ready, flush, store_rx_packet_data, rx_packet_data}, 11'd0);

      // ACK
      snap();
      send_ack();
      chk("ack_packet", rx_packet, 3'd5);
      chk("ack_error", rx_error, 1'b0);
      chk("ack_stores", n_store - s0, 0);
      chk("ack_active", rx_transfer_active, 1'b0);

      // OUT token, matching and foreign address
      send_token(8'hE1, 7'd0, 4'd1);
      chk("out0_packet", rx_packet, 3'd1);
      chk("out0_error", rx_error, 1'b0);
      send_ack();
      send_token(8'hE1, 7'd5, 4'd1);
      chk("out5_packet", rx_packet, 3'd5);
      chk("out5_error", rx_error, 1'b0);

      // DATA0 11 22 33 with good CRC
      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      snap();
      send_data(8'hC3, 3, 1'b0);
      chk("d0_flush", n_flush - f0, 1);
      chk("d0_stores", n_store - s0, 3);
      chk("d0_byte0", stored[s0[7:0]], 8'h11);
      chk("d0_byte1", stored[8'(s0 + 1)], 8'h22);
      chk("d0_byte2", stored[8'(s0 + 2)], 8'h33);
      chk("d0_ready", n_rdy - r0, 1);
      chk("d0_packet", rx_packet, 3'd3);
      chk("d0_error", rx_error, 1'b0);

      // DATA1 FF FF: payload pushes stuffed zeros through
      pl[0] = 8'hFF; pl[1] = 8'hFF;
      snap();
      send_data(8'h4B, 2, 1'b0);
      chk("d1_stores", n_store - s0, 2);
      chk("d1_byte0", stored[s0[7:0]], 8'hFF);
      chk("d1_byte1", stored[8'(s0 + 1)], 8'hFF);
      chk("d1_packet", rx_packet, 3'd4);
      chk("d1_error", rx_error, 1'b0);

      // DATA0 with a corrupted CRC byte
      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      snap();
      send_data(8'hC3, 3, 1'b1);
`ifdef USB_RX_CRC16_EN
      chk("crc_error", rx_error, 1'b1);
      chk("crc_ready", n_rdy - r0, 0);
      chk("crc_packet", rx_packet, 3'd4);
`else
      chk("nocrc_error", rx_error, 1'b0);
      chk("nocrc_ready", n_rdy - r0, 1);
      chk("nocrc_packet", rx_packet, 3'd3);
`endif

      // Seventh consecutive 1 after DATA1 PID
      send_sync(); send_byte(8'h4B);
      for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
      send_eop();
      chk("stuff_error", rx_error, 1'b1);
      chk("stuff_idle", rx_transfer_active, 1'b0);
      send_ack();
      chk("recover_error", rx_error, 1'b0);
      chk("recover_packet", rx_packet, 3'd5);

      // FIFO full on first store attempt
      occ = 7'd64;
      snap();
      send_data(8'hC3, 3, 1'b0);
      chk("full_error", rx_error, 1'b1);
      chk("full_stores", n_store - s0, 0);
      chk("full_ready", n_rdy - r0, 0);
      chk("full_packet", rx_packet, 3'd5);
      occ = 7'd0;

      // Reset in the middle of a DATA payload
      send_sync(); send_byte(8'hC3);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      chk("mid_active", rx_transfer_active, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_outs", {rx_packet, rx_transfer_active, rx_error, rx_data_ready,
                           flush, store_rx_packet_data, rx_packet_data}, 16'd0);
      rst = 1'b0;
      cur = 1'b1;
      for (int i = 0; i < 4; i++) drive(1'b1);
      send_ack();
      chk("post_rst_packet", rx_packet, 3'd5);
      chk("post_rst_error", rx_error, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/usb_rx.md
# usb_rx

USB 1.1 full-speed device receiver; the receive-side counterpart of the device transmitter. Recovers bit timing from the D+/D− line pair, NRZI-decodes, removes stuffed bits, detects SYNC/PID/EOP, classifies host packets and streams DATA payload bytes into the shared endpoint FIFO. It sits between the bus pins and the protocol controller, beside the transmitter, and shares the FIFO with it.

## Interface
- CLKS_PER_BIT, 8: system clocks per USB bit time; even, ≥4.
- DEV_ADDR, 7'd0: device address; tokens for any other address are silently dropped.
- clk  in  1  system clock.
- rst  in  1  one clock; reset is synchronous and active-high.
- dplus_in  in  1  raw D+ (asynchronous).
- dminus_in  in  1  raw D− (asynchronous).
- buffer_occupancy  in  7  FIFO byte count, 0..64.
- rx_packet  out  3  last good packet: 0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK.
- rx_transfer_active  out  1  high from SYNC start to packet end.
- rx_error  out  1  sticky error flag.
- rx_data_ready  out  1  one-cycle pulse at end of a good DATA packet.
- flush  out  1  one-cycle pulse when a DATA PID is accepted.
- store_rx_packet_data  out  1  one-cycle FIFO write strobe.
- rx_packet_data  out  8  byte written when store_rx_packet_data is high.

## Operation
- Input: two-flop synchronizer per line (reset values D+=1, D−=0, idle J); one further register for edge detection.
- Bit timer: counter 0..CLKS_PER_BIT−1; cleared on any synced D+ edge; sample strobe when counter == CLKS_PER_BIT/2; wraps at CLKS_PER_BIT−1.
- NRZI decode at strobe: 1 if D+ equals previous sample, else 0. SE0 (D+=D−=0) is not a data bit.
- Destuffing (after SYNC): ones counter; after six consecutive 1s the next bit is dropped; a dropped bit of 1 is a stuff error.
- Bytes assemble LSB first (right shift in at MSB).
- States: IDLE → SYNC (first J→K edge) → PID (byte == 8'h80, else ERR) → TOKEN (OUT 8'hE1, IN 8'h69), DATA (DATA0 8'hC3, DATA1 8'h4B), or EOP (ACK 8'hD2). PID with low nibble ≠ ~high nibble, or any other PID → ERR.
- TOKEN: 16 bits; addr = bits[6:0]; endpoint and CRC5 ignored; then EOP.
- DATA: flush pulses on PID accept. Two-byte holding pipeline: on completion of each byte from the third onward, oldest held byte is stored. At EOP the two held bytes are CRC16 and never stored. Fewer than 2 bytes after PID → ERR.
- EOP: SE0 at a strobe followed by J at the next strobe. Packet end one cycle later: rx_packet updated (TOKEN only if addr == DEV_ADDR; mismatch updates nothing), rx_data_ready pulses for DATA, → IDLE.
- ERR: rx_error set; waits for EOP then IDLE. SE0 mid-byte, non-J after SE0, stuff error, store while buffer_occupancy == 64 → ERR.
- rx_error and rx_packet hold until the next SYNC start, which clears rx_error only.

## Timing
- Reset: all outputs 0, rx_packet_data 8'h00, state IDLE, timer 0, synchronizers at J.
- Pin-to-decision latency: 2 sync + 1 edge register + CLKS_PER_BIT/2 clocks.
- store_rx_packet_data asserted the cycle after the strobe completing the triggering byte; rx_packet_data valid in the same cycle.
- flush asserted the cycle after the PID-completing strobe.
- Error and packet end never coincide; error wins; rx_data_ready suppressed.
- rst mid-packet: immediate return to reset state; no strobes emitted.

## Configuration
- USB_RX_CRC16_EN defined: bit-serial CRC16 (poly 0x8005, init 0xFFFF) over payload and CRC bytes; residual ≠ 0x800D at EOP → ERR, no rx_data_ready, rx_packet unchanged.
- Undefined: CRC bytes discarded unchecked; CRC logic absent.

## Test plan
- ACK (SYNC, 8'hD2, EOP) → rx_packet=5 one cycle after EOP J; rx_error=0; no stores.
- OUT token addr 0, ep 1 with DEV_ADDR=0 → rx_packet=1; same with addr 5 → rx_packet unchanged, rx_error=0.
- DATA0 payload 8'h11, 8'h22, 8'h33 + valid CRC → flush once, exactly three stores in order, rx_data_ready pulse, rx_packet=3; with USB_RX_CRC16_EN and CRC corrupted → rx_error=1, no rx_data_ready.
- DATA1 payload 8'hFF, 8'hFF: stuffed zeros removed, stores 8'hFF twice; forcing seventh consecutive 1 → rx_error=1, return to IDLE after EOP.
- DATA0 with buffer_occupancy held at 64 → first store attempt sets rx_error, no store strobe.
- rst asserted mid-DATA payload → all outputs 0 next cycle; following ACK packet decodes correctly.
